r8051_xram_arb: RTL and testbench

External-data-memory arbiter between the r8051 core's xdata ports and a DMA/debug master, driving one single-port synchronous SRAM. It serialises core writes, core reads and DMA accesses to one SRAM access per cycle. It generates the core's `ram_rd_vld` read-return strobe and provides a DMA starvation guard. It sits between the core's `ram_*_xdata` ports and the xdata SRAM macro.

---
 rtl/r8051_xram_arb.sv | 147 ++++++++++++++
 tb/tb_r8051_xram_arb.sv | 268 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/r8051_xram_arb.sv
`default_nettype none
// ============================================================================
// r8051_xram_arb : single-port xdata SRAM arbiter between the r8051 core and a
//                  DMA/debug master, with read-return tracking and DMA starvation guard.
// Revision       : 1.0
// ============================================================================
module r8051_xram_arb #(
  parameter int ADDR_W     = 16,
  parameter int STARVE_LIM = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              xrd_en,
  input  logic [ADDR_W-1:0] xrd_addr,
  output logic [7:0]        xrd_byte,
  output logic              xrd_vld,
  input  logic              xwr_en,
  input  logic [ADDR_W-1:0] xwr_addr,
  input  logic [7:0]        xwr_byte,
  input  logic              dma_req,
  input  logic              dma_we,
  input  logic [ADDR_W-1:0] dma_addr,
  input  logic [7:0]        dma_wdata,
  output logic              dma_gnt,
  output logic              dma_rvld,
  output logic [7:0]        dma_rdata,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [7:0]        mem_wdata,
  input  logic [7:0]        mem_rdata,
  output logic              ovf_err
);

  localparam logic [1:0] C_RSP_NONE = 2'd0;
  localparam logic [1:0] C_RSP_CORE = 2'd1;
  localparam logic [1:0] C_RSP_DMA  = 2'd2;
  localparam logic [3:0] C_STARVE_LIM = 4'(STARVE_LIM);

  logic [1:0]        rsp_sel_q, rsp_sel_d;
  logic              rd_pend_q, rd_pend_d;
  logic [ADDR_W-1:0] rd_addr_q, rd_addr_d;
  logic [3:0]        starve_cnt_q, starve_cnt_d;
  logic              ovf_err_q, ovf_err_d;

  logic              w_run;
  logic              w_starved;
  logic              w_rd_req;
  logic [ADDR_W-1:0] w_rd_addr;
  logic              w_gnt_wr, w_gnt_dma, w_gnt_rd;

  // Everything outward-facing is held quiet while reset is asserted.
  assign w_run     = rst;
  assign w_starved = (starve_cnt_q == C_STARVE_LIM);
  assign w_rd_req  = rd_pend_q | xrd_en;
  assign w_rd_addr = rd_pend_q ? rd_addr_q : xrd_addr;

  always_comb begin
    w_gnt_wr  = 1'b0;
    w_gnt_dma = 1'b0;
    w_gnt_rd  = 1'b0;
    if (w_run) begin
      if (xwr_en)                     w_gnt_wr  = 1'b1;
      else if (dma_req && w_starved)  w_gnt_dma = 1'b1;
      else if (w_rd_req)              w_gnt_rd  = 1'b1;
      else if (dma_req)               w_gnt_dma = 1'b1;
    end
  end

  always_comb begin
    mem_en    = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    if (w_gnt_wr) begin
      mem_en    = 1'b1;
      mem_we    = 1'b1;
      mem_addr  = xwr_addr;
      mem_wdata = xwr_byte;
    end else if (w_gnt_dma) begin
      mem_en    = 1'b1;
      mem_we    = dma_we;
      mem_addr  = dma_addr;
      mem_wdata = dma_we ? dma_wdata : 8'h00;
    end else if (w_gnt_rd) begin
      mem_en    = 1'b1;
      mem_addr  = w_rd_addr;
    end
  end

  assign dma_gnt = w_gnt_dma;

  // A read that loses arbitration is parked; a second one while parked is lost.
  always_comb begin
    rd_pend_d = rd_pend_q;
    rd_addr_d = rd_addr_q;
    if (rd_pend_q) begin
      if (w_gnt_rd) rd_pend_d = 1'b0;
    end else if (xrd_en && !w_gnt_rd) begin
      rd_pend_d = 1'b1;
      rd_addr_d = xrd_addr;
    end
    ovf_err_d = ovf_err_q | (xrd_en & rd_pend_q);
  end

  always_comb begin
    starve_cnt_d = starve_cnt_q;
    if (!dma_req || w_gnt_dma)           starve_cnt_d = 4'd0;
    else if (starve_cnt_q < C_STARVE_LIM) starve_cnt_d = starve_cnt_q + 4'd1;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      rd_pend_q    <= 1'b0;
      rd_addr_q    <= '0;
      starve_cnt_q <= 4'd0;
      ovf_err_q    <= 1'b0;
    end else begin
      rd_pend_q    <= rd_pend_d;
      rd_addr_q    <= rd_addr_d;
      starve_cnt_q <= starve_cnt_d;
      ovf_err_q    <= ovf_err_d;
    end
  end

  // Response tracker: remembers who owns the SRAM read data returning next cycle.
  always_ff @(posedge clk) begin
    if (!rst) rsp_sel_q <= C_RSP_NONE;
    else      rsp_sel_q <= rsp_sel_d;
  end

  always_comb begin
    rsp_sel_d = C_RSP_NONE;
    if (w_gnt_rd)                rsp_sel_d = C_RSP_CORE;
    else if (w_gnt_dma && !dma_we) rsp_sel_d = C_RSP_DMA;
  end

  always_comb begin
    xrd_vld   = w_run && (rsp_sel_q == C_RSP_CORE);
    dma_rvld  = w_run && (rsp_sel_q == C_RSP_DMA);
    xrd_byte  = xrd_vld  ? mem_rdata : 8'h00;
    dma_rdata = dma_rvld ? mem_rdata : 8'h00;
    ovf_err   = w_run & ovf_err_q;
  end

endmodule
`default_nettype wire

// File: tb/tb_r8051_xram_arb.sv
`default_nettype none
// ============================================================================
// tb_r8051_xram_arb : directed scoreboard bench for r8051_xram_arb.
// Revision          : 1.0
// ============================================================================
module tb_r8051_xram_arb;

  localparam int ADDR_W     = 16;
  localparam int STARVE_LIM = 4;

  logic              clk = 1'b0;
  logic              rst;
  logic              xrd_en;
  logic [ADDR_W-1:0] xrd_addr;
  logic [7:0]        xrd_byte;
  logic              xrd_vld;
  logic              xwr_en;
  logic [ADDR_W-1:0] xwr_addr;
  logic [7:0]        xwr_byte;
  logic              dma_req;
  logic              dma_we;
  logic [ADDR_W-1:0] dma_addr;
  logic [7:0]        dma_wdata;
  logic              dma_gnt;
  logic              dma_rvld;
  logic [7:0]        dma_rdata;
  logic              mem_en;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [7:0]        mem_wdata;
  logic [7:0]        mem_rdata;
  logic              ovf_err;

  always #5 clk = ~clk;

  r8051_xram_arb #(.ADDR_W(ADDR_W), .STARVE_LIM(STARVE_LIM)) dut (
    .clk(clk), .rst(rst),
    .xrd_en(xrd_en), .xrd_addr(xrd_addr), .xrd_byte(xrd_byte), .xrd_vld(xrd_vld),
    .xwr_en(xwr_en), .xwr_addr(xwr_addr), .xwr_byte(xwr_byte),
    .dma_req(dma_req), .dma_we(dma_we), .dma_addr(dma_addr), .dma_wdata(dma_wdata),
    .dma_gnt(dma_gnt), .dma_rvld(dma_rvld), .dma_rdata(dma_rdata),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .ovf_err(ovf_err)
  );

  // SRAM contents before any write.
  function automatic logic [7:0] init_byte(input logic [15:0] a);
    case (a)
      16'h1234: return 8'h5A;
      16'h0200: return 8'h3C;
      default:  return a[7:0] ^ a[15:8] ^ 8'h96;
    endcase
  endfunction

  logic [7:0] sram [int];
  always @(posedge clk) begin
    if (mem_en) begin
      if (mem_we) sram[int'(mem_addr)] = mem_wdata;
      else mem_rdata <= sram.exists(int'(mem_addr)) ? sram[int'(mem_addr)] : init_byte(mem_addr);
    end
  end

  // Expected memory image, maintained only from the stimulus side.
  logic [7:0] exp_mem [int];
  function automatic logic [7:0] exp_rd(input logic [15:0] a);
    return exp_mem.exists(int'(a)) ? exp_mem[int'(a)] : init_byte(a);
  endfunction

  logic [7:0] core_q [$];
  logic [7:0] dma_q  [$];
  int n_checks = 0;
  int n_fails  = 0;
  bit mon_on   = 1'b0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fails++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] all_outs();
    return {18'b0, xrd_vld, xrd_byte, dma_gnt, dma_rvld, dma_rdata,
            mem_en, mem_we, mem_addr, mem_wdata, ovf_err};
  endfunction

  task automatic chk_rd(input string tag, input logic [15:0] a);
    check(tag, {mem_en, mem_we, mem_addr}, {1'b1, 1'b0, a});
  endtask

  task automatic chk_wr(input string tag, input logic [15:0] a, input logic [7:0] d);
    check(tag, {mem_en, mem_we, mem_addr, mem_wdata}, {1'b1, 1'b1, a, d});
  endtask

  task automatic nxt();
    @(posedge clk);
    #1;
  endtask

  task automatic clr_pulses();
    xrd_en = 1'b0;
    xwr_en = 1'b0;
  endtask

  // Scoreboard side: every read return is matched against the queued expectation.
  always @(negedge clk) begin
    if (mon_on) begin
      check("vld_exclusive", {63'b0, xrd_vld & dma_rvld}, 64'd0);
      if (xrd_vld) begin
        if (core_q.size() == 0) check("xrd_vld_unexpected", {63'b0, xrd_vld}, 64'd0);
        else check("xrd_byte", {56'b0, xrd_byte}, {56'b0, core_q.pop_front()});
      end else check("xrd_byte_idle", {56'b0, xrd_byte}, 64'd0);
      if (dma_rvld) begin
        if (dma_q.size() == 0) check("dma_rvld_unexpected", {63'b0, dma_rvld}, 64'd0);
        else check("dma_rdata", {56'b0, dma_rdata}, {56'b0, dma_q.pop_front()});
      end else check("dma_rdata_idle", {56'b0, dma_rdata}, 64'd0);
      if (!mem_en) check("mem_idle_zero", {mem_we, mem_addr, mem_wdata}, 64'd0);
    end
  end

  initial begin
    rst = 1'b0;
    xrd_en = 1'b0; xrd_addr = '0;
    xwr_en = 1'b0; xwr_addr = '0; xwr_byte = '0;
    dma_req = 1'b0; dma_we = 1'b0; dma_addr = '0; dma_wdata = '0;

    // Requests presented while in reset must not reach the SRAM.
    nxt(); nxt();
    xwr_en = 1'b1; xwr_addr = 16'h0055; xwr_byte = 8'hEE;
    dma_req = 1'b1; dma_addr = 16'h0056;
    @(negedge clk);
    check("reset_outputs", all_outs(), 64'd0);
    nxt();
    clr_pulses(); dma_req = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    check("post_reset_idle", all_outs(), 64'd0);
    mon_on = 1'b1;
    nxt();

    // Uncontended core read.
    xrd_en = 1'b1; xrd_addr = 16'h1234;
    core_q.push_back(exp_rd(16'h1234));
    @(negedge clk);
    chk_rd("rd_issue_T", 16'h1234);
    nxt(); clr_pulses();
    @(negedge clk);
    check("rd_vld_T1", {63'b0, xrd_vld}, 64'd1);
    check("rd_byte_5A", {56'b0, xrd_byte}, 64'h5A);
    nxt();

    // Same-cycle write and read of one address.
    xwr_en = 1'b1; xwr_addr = 16'h0010; xwr_byte = 8'hA5; exp_mem[16'h0010] = 8'hA5;
    xrd_en = 1'b1; xrd_addr = 16'h0010;
    core_q.push_back(exp_rd(16'h0010));
    @(negedge clk);
    chk_wr("wr_first", 16'h0010, 8'hA5);
    nxt(); clr_pulses();
    @(negedge clk);
    chk_rd("rd_after_wr", 16'h0010);
    check("no_vld_T1", {63'b0, xrd_vld}, 64'd0);
    nxt();
    @(negedge clk);
    check("wr_rd_vld_T2", {63'b0, xrd_vld}, 64'd1);
    nxt();

    // DMA read against an idle core, then back-to-back DMA reads.
    dma_req = 1'b1; dma_we = 1'b0; dma_addr = 16'h0200;
    dma_q.push_back(exp_rd(16'h0200));
    @(negedge clk);
    check("dma_gnt_idle", {63'b0, dma_gnt}, 64'd1);
    chk_rd("dma_rd_issue", 16'h0200);
    nxt();
    dma_addr = 16'h0201; dma_q.push_back(exp_rd(16'h0201));
    @(negedge clk);
    check("dma_rvld_G1", {58'b0, dma_rvld, dma_gnt, dma_rdata[3:0]}, {58'b0, 1'b1, 1'b1, 4'hC});
    nxt();
    dma_addr = 16'h0202; dma_q.push_back(exp_rd(16'h0202));
    @(negedge clk);
    check("dma_b2b_gnt", {63'b0, dma_gnt}, 64'd1);
    nxt();
    dma_req = 1'b0;
    @(negedge clk);
    check("dma_b2b_rvld", {62'b0, dma_rvld, dma_gnt}, {62'b0, 1'b1, 1'b0});
    nxt();

    // Starvation: DMA write held while core alternates reads and writes.
    dma_req = 1'b1; dma_we = 1'b1; dma_addr = 16'h0300; dma_wdata = 8'h77;
    for (int i = 0; i < 6; i++) begin
      clr_pulses();
      if (i == 5) dma_req = 1'b0;
      if (i % 2 == 0) begin
        xrd_en = 1'b1; xrd_addr = 16'h0400 + 16'(i);
        core_q.push_back(exp_rd(xrd_addr));
      end else begin
        xwr_en = 1'b1; xwr_addr = 16'h0500 + 16'(i); xwr_byte = 8'h80 + 8'(i);
        exp_mem[int'(xwr_addr)] = xwr_byte;
      end
      @(negedge clk);
      check("starve_gnt", {63'b0, dma_gnt}, {63'b0, (i == 4)});
      if (i % 2 == 1) chk_wr("starve_wr_kept", xwr_addr, xwr_byte);
      else if (i == 4) begin
        chk_wr("starve_dma_wr", 16'h0300, 8'h77);
        exp_mem[16'h0300] = 8'h77;
      end else chk_rd("starve_rd", xrd_addr);
      nxt();
    end
    clr_pulses();
    @(negedge clk);
    chk_rd("pend_rd_issue", 16'h0404);
    nxt();
    @(negedge clk);
    check("pend_rd_vld", {63'b0, xrd_vld}, 64'd1);
    nxt();

    // Core read outranks a fresh DMA read; DMA follows next cycle.
    xrd_en = 1'b1; xrd_addr = 16'h0501; core_q.push_back(exp_rd(16'h0501));
    dma_req = 1'b1; dma_we = 1'b0; dma_addr = 16'h0300; dma_q.push_back(exp_rd(16'h0300));
    @(negedge clk);
    check("core_over_dma", {63'b0, dma_gnt}, 64'd0);
    nxt(); clr_pulses();
    @(negedge clk);
    check("dma_after_core", {63'b0, dma_gnt}, 64'd1);
    nxt(); dma_req = 1'b0;
    nxt();

    // Read overflow.
    xwr_en = 1'b1; xwr_addr = 16'h0600; xwr_byte = 8'h11; exp_mem[16'h0600] = 8'h11;
    xrd_en = 1'b1; xrd_addr = 16'h0601; core_q.push_back(exp_rd(16'h0601));
    @(negedge clk);
    check("ovf_low_T", {63'b0, ovf_err}, 64'd0);
    nxt(); clr_pulses();
    xrd_en = 1'b1; xrd_addr = 16'h0602;
    @(negedge clk);
    chk_rd("ovf_pend_issue", 16'h0601);
    check("ovf_low_T1", {63'b0, ovf_err}, 64'd0);
    nxt(); clr_pulses();
    @(negedge clk);
    check("ovf_T2", {62'b0, ovf_err, xrd_vld}, {62'b0, 1'b1, 1'b1});
    nxt();
    @(negedge clk);
    check("ovf_sticky", {62'b0, ovf_err, xrd_vld}, {62'b0, 1'b1, 1'b0});
    nxt();

    // Reset while a read is in flight.
    xrd_en = 1'b1; xrd_addr = 16'h0700;
    @(negedge clk);
    chk_rd("rst_rd_issue", 16'h0700);
    nxt(); clr_pulses();
    rst = 1'b0;
    @(negedge clk);
    check("rst_mid_outputs", all_outs(), 64'd0);
    nxt();
    rst = 1'b1;
    @(negedge clk);
    check("rst_no_vld", all_outs(), 64'd0);
    nxt(); nxt();

    check("core_sb_drained", 64'(core_q.size()), 64'd0);
    check("dma_sb_drained", 64'(dma_q.size()), 64'd0);
    mon_on = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
`default_nettype wire
